// File: rtl/note_detector_pkg.sv
// Shared constants, threshold table and state types for the note detector.
package note_detector_pkg;

    localparam int unsigned SUM_W     = 13;
    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned NUM_NOTES = 16;

    typedef logic [SUM_W-1:0] sum_t;

    localparam sum_t MIN_SUM = 13'd148;
    localparam sum_t MAX_SUM = 13'd784;

    // Decision thresholds: a window sum above T[i] (first such i) selects note i.
    localparam sum_t THRESH [NUM_NOTES] = '{
        13'd694, 13'd617, 13'd566, 13'd520, 13'd463, 13'd412, 13'd378, 13'd347,
        13'd309, 13'd283, 13'd260, 13'd231, 13'd206, 13'd189, 13'd174, 13'd147
    };

    // Nominal 4-period sums of each note at 48 kHz.
    localparam sum_t P_SUM [NUM_NOTES] = '{
        13'd736, 13'd653, 13'd582, 13'd550, 13'd490, 13'd436, 13'd389, 13'd367,
        13'd327, 13'd291, 13'd275, 13'd245, 13'd218, 13'd194, 13'd184, 13'd164
    };

    typedef enum logic {ST_IDLE, ST_MEASURE} det_state_e;
    typedef enum logic {CL_IDLE, CL_SEARCH}  cls_state_e;

    function automatic logic sum_in_range(input sum_t s);
        return (s >= MIN_SUM) && (s <= MAX_SUM);
    endfunction

endpackage

// File: rtl/note_classifier.sv
// Sequential 16-step threshold search; idx 0 is evaluated on the start cycle
// against the incoming sum so done/idx land registered 16 edges later.
module note_classifier
    import note_detector_pkg::*;
(
    input  logic              clk_48kHz,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              start,
    input  logic [SUM_W-1:0]  sum,
    output logic              done,
    output logic [NOTE_W-1:0] idx
);

    localparam logic [NOTE_W-1:0] LAST_STEP = NOTE_W'(NUM_NOTES - 1);

    cls_state_e        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, cur_sum_c;
    logic [NOTE_W-1:0] step_q, cur_step_c, res_q;
    logic              found_q, first_found_c, active_c, hit_c;

    always_comb begin
        state_d       = state_q;
        active_c      = 1'b0;
        cur_step_c    = step_q;
        cur_sum_c     = sum_q;
        first_found_c = found_q;
        if (start) begin
            active_c      = 1'b1;
            cur_step_c    = '0;
            cur_sum_c     = sum;
            first_found_c = 1'b0;
        end else if (state_q == CL_SEARCH) begin
            active_c = 1'b1;
        end
        hit_c = active_c && (cur_sum_c > THRESH[cur_step_c]);
        if (abort) begin
            state_d = CL_IDLE;
        end else if (active_c) begin
            state_d = (cur_step_c == LAST_STEP) ? CL_IDLE : CL_SEARCH;
        end
    end

    always_ff @(posedge clk_48kHz) begin
        if (!rst_n) begin
            state_q <= CL_IDLE;
            sum_q   <= '0;
            step_q  <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (active_c && !abort) begin
                sum_q  <= cur_sum_c;
                step_q <= cur_step_c + NOTE_W'(1);
                if (hit_c && !first_found_c) begin
                    res_q   <= cur_step_c;
                    found_q <= 1'b1;
                end else begin
                    found_q <= first_found_c;
                end
                // The last threshold is below MIN_SUM, so an unmatched search ends on it.
                if (cur_step_c == LAST_STEP) begin
                    done <= 1'b1;
                    idx  <= first_found_c ? res_q : cur_step_c;
                end
            end
        end
    end

endmodule

// File: rtl/note_detector.sv
// Decodes a synthesised tone back to its note index: Schmitt crossings,
// 4-period window sums, threshold classification and two-window debounce.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int unsigned WIDTH_P   = 24,
    parameter int unsigned HYST_P    = 4096,
    parameter int unsigned TIMEOUT_P = 1024
) (
    input  logic                      clk_48kHz,
    input  logic                      rst_n,
    input  logic signed [WIDTH_P-1:0] sample_i,
    input  logic                      sample_valid_i,
    output logic [NOTE_W-1:0]         note_o,
    output logic                      note_valid_o,
    output logic                      note_change_o,
    output logic [SUM_W-1:0]          period_sum_o
);

    localparam logic signed [WIDTH_P-1:0] HYST_POS    = WIDTH_P'(HYST_P);
    localparam logic signed [WIDTH_P-1:0] HYST_NEG    = -HYST_POS;
    localparam logic [CNT_W-1:0]          TIMEOUT_CNT = CNT_W'(TIMEOUT_P);

    det_state_e        state_q, state_d;
    logic              schmitt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  sum_q, sum_d, snapshot_c;
    logic [1:0]        k_q, k_d;
    logic [NOTE_W-1:0] cand_q;
    logic              cand_valid_q;
    logic              crossing_c, timeout_c, window_close_c, in_range_c, cls_start_c;
    logic              cls_done;
    logic [NOTE_W-1:0] cls_idx;

    assign crossing_c     = sample_valid_i && !schmitt_q && (sample_i >= HYST_POS);
    assign timeout_c      = sample_valid_i && !crossing_c && (cnt_q >= TIMEOUT_CNT);
    assign snapshot_c     = sum_q + SUM_W'(cnt_q);
    assign window_close_c = crossing_c && (state_q == ST_MEASURE) && (k_q == 2'd3);
    assign in_range_c     = sum_in_range(snapshot_c);
    assign cls_start_c    = window_close_c && in_range_c;

    // Window accumulation; the closing crossing also opens the next window.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        k_d     = k_q;
        if (crossing_c) begin
            if (state_q == ST_IDLE) begin
                state_d = ST_MEASURE;
                sum_d   = '0;
                k_d     = '0;
            end else if (k_q == 2'd3) begin
                sum_d = '0;
                k_d   = '0;
            end else begin
                sum_d = snapshot_c;
                k_d   = k_q + 2'd1;
            end
        end else if (timeout_c) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_48kHz) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
        end
    end

    // Schmitt state and period counter advance on valid samples only.
    always_ff @(posedge clk_48kHz) begin
        if (!rst_n) begin
            schmitt_q <= 1'b0;
            cnt_q     <= '0;
        end else if (sample_valid_i) begin
            if (crossing_c) begin
                schmitt_q <= 1'b1;
            end else if (sample_i <= HYST_NEG) begin
                schmitt_q <= 1'b0;
            end
            if (crossing_c) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q < TIMEOUT_CNT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    note_classifier u_classifier (
        .clk_48kHz (clk_48kHz),
        .rst_n     (rst_n),
        .abort     (timeout_c),
        .start     (cls_start_c),
        .sum       (snapshot_c),
        .done      (cls_done),
        .idx       (cls_idx)
    );

    // Result handling: a note is published only when two consecutive windows agree.
    always_ff @(posedge clk_48kHz) begin
        if (!rst_n) begin
            note_o        <= '0;
            note_valid_o  <= 1'b0;
            note_change_o <= 1'b0;
            period_sum_o  <= '0;
            cand_q        <= '0;
            cand_valid_q  <= 1'b0;
        end else begin
            note_change_o <= 1'b0;
            if (timeout_c || (window_close_c && !in_range_c)) begin
                note_valid_o <= 1'b0;
                cand_valid_q <= 1'b0;
            end else begin
                if (cls_start_c) begin
                    period_sum_o <= snapshot_c;
                end
                if (cls_done) begin
                    if (cand_valid_q && (cls_idx == cand_q)) begin
                        if (!note_valid_o || (note_o != cls_idx)) begin
                            note_o        <= cls_idx;
                            note_valid_o  <= 1'b1;
                            note_change_o <= 1'b1;
                        end
                    end else begin
                        cand_q       <= cls_idx;
                        cand_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Directed tone scenarios with randomized amplitude/valid gaps, checked every
// cycle against a list-based behavioural model of the note detector.
`timescale 1ns/1ps
module tb_note_detector;

    logic               clk_48kHz = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [23:0] sample_i = '0;
    logic               sample_valid_i = 1'b0;
    logic [3:0]         note_o;
    logic               note_valid_o, note_change_o;
    logic [12:0]        period_sum_o;

    always #10 clk_48kHz = ~clk_48kHz;

    note_detector #(.WIDTH_P(24), .HYST_P(4096), .TIMEOUT_P(1024)) dut (
        .clk_48kHz      (clk_48kHz),
        .rst_n          (rst_n),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .note_o         (note_o),
        .note_valid_o   (note_valid_o),
        .note_change_o  (note_change_o),
        .period_sum_o   (period_sum_o)
    );

    int asserts = 0;
    int fails   = 0;
    int thr [16] = '{694, 617, 566, 520, 463, 412, 378, 347, 309, 283, 260, 231, 206, 189, 174, 147};

    // Reference model state: crossing history and scheduled classifier results.
    bit m_hi, m_meas, m_pend, m_valid, m_change, m_cand_v;
    int m_per[$];
    int m_n, m_last, m_pend_at, m_pend_note, m_note, m_psum, m_cand;
    int cyc = 0;
    int xcount, cross9_cyc, last_cross_cyc, chg_count, first_chg_cyc, valid_seen;

    function automatic int classify(input int s);
        for (int i = 0; i < 16; i++) if (s > thr[i]) return i;
        return 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_meas = 0; m_pend = 0; m_valid = 0; m_change = 0; m_cand_v = 0;
        m_per.delete();
        m_n = 0; m_last = 0; m_note = 0; m_psum = 0; m_cand = 0;
        xcount = 0; cross9_cyc = -100000; last_cross_cyc = -100000;
        chg_count = 0; first_chg_cyc = -1; valid_seen = 0;
    endtask

    task automatic debounce(input int r);
        if (m_cand_v && r == m_cand) begin
            if (!m_valid || m_note != r) begin
                m_note = r; m_valid = 1; m_change = 1;
            end
        end else begin
            m_cand = r; m_cand_v = 1;
        end
    endtask

    task automatic model_clock(input int s, input bit v);
        bit x;
        int per, tot;
        m_change = 0;
        if (m_pend && cyc == m_pend_at) begin
            m_pend = 0;
            debounce(m_pend_note);
        end
        if (v) begin
            x = !m_hi && s >= 4096;
            if (x) m_hi = 1;
            else if (s <= -4096) m_hi = 0;
            if (x) begin
                per = m_n - m_last;
                if (per > 1024) per = 1024;
                m_last = m_n;
                xcount++;
                last_cross_cyc = cyc;
                if (xcount == 9) cross9_cyc = cyc;
                if (!m_meas) begin
                    m_meas = 1;
                    m_per.delete();
                end else begin
                    m_per.push_back(per);
                    if (m_per.size() == 4) begin
                        tot = 0;
                        foreach (m_per[i]) tot += m_per[i];
                        m_per.delete();
                        if (tot >= 148 && tot <= 784) begin
                            m_psum = tot; m_pend = 1; m_pend_at = cyc + 16; m_pend_note = classify(tot);
                        end else begin
                            m_valid = 0; m_cand_v = 0;
                        end
                    end
                end
            end else if (m_n - m_last >= 1024) begin
                m_meas = 0; m_valid = 0; m_cand_v = 0; m_pend = 0;
                m_per.delete();
            end
            m_n++;
        end
    endtask

    // One clock: drive, advance the model at the edge, compare #1 later.
    task automatic step(input logic signed [23:0] s, input bit v);
        sample_i = s;
        sample_valid_i = v;
        @(posedge clk_48kHz);
        if (!rst_n) model_reset();
        else model_clock(int'(s), v);
        #1;
        check("note_o", 32'(note_o), 32'(m_note));
        check("note_valid_o", 32'(note_valid_o), 32'(m_valid));
        check("note_change_o", 32'(note_change_o), 32'(m_change));
        check("period_sum_o", 32'(period_sum_o), 32'(m_psum));
        if (note_change_o) begin
            chg_count++;
            if (first_chg_cyc < 0) first_chg_cyc = cyc;
        end
        if (note_valid_o) valid_seen++;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step('0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Square wave in valid samples: high for the first half of each period.
    task automatic tone(input int p, input int nvalid, input int amp, input int vpct);
        int ph;
        int a;
        logic signed [23:0] sv;
        ph = 0;
        while (ph < nvalid) begin
            if ($urandom_range(99) < vpct) begin
                a = amp + int'($urandom_range(amp / 8));
                sv = 24'(a);
                if ((ph % p) >= p / 2) sv = -sv;
                step(sv, 1'b1);
                ph++;
            end else begin
                step(24'($urandom), 1'b0);
            end
        end
    endtask

    initial begin
        int fall_cyc;

        // Reset state and clean 110-sample tone.
        do_reset();
        check("reset_note", 32'(note_o), 32'd0);
        check("reset_psum", 32'(period_sum_o), 32'd0);
        tone(110, 110 * 12, 1 << 22, 100);
        check("t110_note", 32'(note_o), 32'd5);
        check("t110_valid", 32'(note_valid_o), 32'd1);
        check("t110_psum", 32'(period_sum_o), 32'd440);
        check("t110_pulses", 32'(chg_count), 32'd1);
        check("t110_latency", 32'(first_chg_cyc + 1 - cross9_cyc), 32'd17);

        // Extremes of the table.
        do_reset();
        tone(184, 184 * 10, 1 << 22, 100);
        check("t184_note", 32'(note_o), 32'd0);
        check("t184_psum", 32'(period_sum_o), 32'd736);
        do_reset();
        tone(46, 46 * 14, 1 << 22, 100);
        check("t46_note", 32'(note_o), 32'd14);
        check("t46_psum", 32'(period_sum_o), 32'd184);

        // Threshold boundary: 463 stays note 5, 464 becomes note 4.
        do_reset();
        repeat (3) begin
            tone(115, 115, 1 << 21, 100);
            tone(116, 348, 1 << 21, 100);
        end
        check("b463_note", 32'(note_o), 32'd5);
        check("b463_psum", 32'(period_sum_o), 32'd463);
        do_reset();
        tone(116, 116 * 12, 1 << 21, 100);
        check("b464_note", 32'(note_o), 32'd4);
        check("b464_psum", 32'(period_sum_o), 32'd464);

        // Note switch needs two agreeing windows and pulses once.
        do_reset();
        tone(110, 110 * 12, 1 << 22, 100);
        chg_count = 0;
        tone(82, 82 * 16, 1 << 22, 100);
        check("sw_note", 32'(note_o), 32'd8);
        check("sw_valid", 32'(note_valid_o), 32'd1);
        check("sw_pulses", 32'(chg_count), 32'd1);

        // Silence after lock: timeout drops valid, holds note, no pulse.
        do_reset();
        tone(110, 110 * 12, 1 << 22, 100);
        chg_count = 0;
        fall_cyc = -1;
        repeat (1100) begin
            step('0, 1'b1);
            if (fall_cyc < 0 && !note_valid_o) fall_cyc = cyc - 1;
        end
        check("to_delay", 32'(fall_cyc - last_cross_cyc), 32'd1024);
        check("to_note", 32'(note_o), 32'd5);
        check("to_pulses", 32'(chg_count), 32'd0);

        // Below hysteresis, and out-of-range period.
        do_reset();
        tone(110, 110 * 12, 2000, 100);
        check("low_amp_valid_seen", 32'(valid_seen), 32'd0);
        do_reset();
        tone(250, 250 * 10, 1 << 22, 100);
        check("t250_valid", 32'(note_valid_o), 32'd0);
        check("t250_psum", 32'(period_sum_o), 32'd0);

        // Gapped valid strobe.
        do_reset();
        tone(110, 110 * 12, 1 << 22, 50);
        check("gap_note", 32'(note_o), 32'd5);
        check("gap_valid", 32'(note_valid_o), 32'd1);
        check("gap_psum", 32'(period_sum_o), 32'd440);
        check("gap_pulses", 32'(chg_count), 32'd1);

        // Reset during a classifier search, then relock from scratch.
        do_reset();
        tone(110, 445, 1 << 22, 100);
        do_reset();
        check("mid_rst_psum", 32'(period_sum_o), 32'd0);
        check("mid_rst_valid", 32'(note_valid_o), 32'd0);
        check("mid_rst_change", 32'(note_change_o), 32'd0);
        tone(110, 110 * 12, 1 << 22, 100);
        check("relock_note", 32'(note_o), 32'd5);
        check("relock_latency", 32'(first_chg_cyc + 1 - cross9_cyc), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
